// File: rtl/slice_insert_unit_pkg.sv
// Shared definitions for the slice insert unit: element geometry and FSM encodings.
package slice_insert_unit_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int NUM_ELEM   = 64;
  localparam int PATCH_ELEM = 16;
  localparam int IDX_W      = 6;
  localparam int SEL_W      = 4;
  localparam int CNT_W      = 5;

  localparam int VEC_W   = NUM_ELEM * DATA_WIDTH;
  localparam int PATCH_W = PATCH_ELEM * DATA_WIDTH;

  typedef enum logic [1:0] {
    SIU_IDLE    = 2'd0,
    SIU_COLLECT = 2'd1,
    SIU_OUTPUT  = 2'd2
  } siu_state_t;

  // Beat counter holds at its maximum rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/slice_insert_unit_mask_gen.sv
// Per-position write enable and patch source select derived from a beat's index window.
module slice_insert_unit_mask_gen
  import slice_insert_unit_pkg::*;
(
  input  logic [IDX_W-1:0]          start_idx,
  input  logic [IDX_W-1:0]          end_idx,
  output logic [NUM_ELEM-1:0]       wr_mask,
  output logic [NUM_ELEM*SEL_W-1:0] src_sel
);

  logic w_window_ok;

  assign w_window_ok = (start_idx <= end_idx);

  for (genvar k = 0; k < NUM_ELEM; k++) begin : g_pos
    localparam logic [IDX_W:0] K = (IDX_W+1)'(k);
    logic [IDX_W:0] w_offset;

    // Offset is only meaningful when k >= start_idx; the in_window term guards it.
    assign w_offset = K - {1'b0, start_idx};

    assign wr_mask[k] = w_window_ok
                      && (K >= {1'b0, start_idx})
                      && (K <= {1'b0, end_idx})
                      && (w_offset < (IDX_W+1)'(PATCH_ELEM));

    assign src_sel[k*SEL_W +: SEL_W] = w_offset[SEL_W-1:0];
  end

endmodule

// File: rtl/slice_insert_unit.sv
// Patches a 64-element base vector with windowed beats and emits the result on valid/ready.
//
//  state        | meaning
//  -------------+------------------------------------------------------------
//  SIU_IDLE     | waiting for a base vector, base_ready high
//  SIU_COLLECT  | applying patch beats to the buffer, patch_ready high
//  SIU_OUTPUT   | data_out/out_valid held until downstream takes it
module slice_insert_unit
  import slice_insert_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [VEC_W-1:0]     base_in,
  input  logic                 base_valid,
  output logic                 base_ready,
  input  logic [PATCH_W-1:0]   patch_in,
  input  logic [IDX_W-1:0]     start_idx,
  input  logic [IDX_W-1:0]     end_idx,
  input  logic                 patch_last,
  input  logic                 patch_valid,
  output logic                 patch_ready,
  output logic [VEC_W-1:0]     data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 idx_err,
  output logic [CNT_W-1:0]     beat_count
);

  siu_state_t r_state;
  siu_state_t w_state_next;

  logic [VEC_W-1:0]  r_buf;
  logic [VEC_W-1:0]  r_data_out;
  logic              r_out_valid;
  logic              r_idx_err;
  logic [CNT_W-1:0]  r_beat_count;

  logic                     w_base_hs;
  logic                     w_patch_hs;
  logic                     w_out_hs;
  logic                     w_idx_bad;
  logic [NUM_ELEM-1:0]      w_wr_mask;
  logic [NUM_ELEM*SEL_W-1:0] w_src_sel;
  logic [DATA_WIDTH-1:0]    w_patch_elem [PATCH_ELEM];
  logic [VEC_W-1:0]         w_next_buf;

  slice_insert_unit_mask_gen u_mask_gen (
    .start_idx (start_idx),
    .end_idx   (end_idx),
    .wr_mask   (w_wr_mask),
    .src_sel   (w_src_sel)
  );

  for (genvar i = 0; i < PATCH_ELEM; i++) begin : g_unpack
    assign w_patch_elem[i] = patch_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // An inverted window yields an all-zero mask, so the buffer passes through untouched.
  for (genvar k = 0; k < NUM_ELEM; k++) begin : g_wr_mux
    assign w_next_buf[k*DATA_WIDTH +: DATA_WIDTH] =
      w_wr_mask[k] ? w_patch_elem[w_src_sel[k*SEL_W +: SEL_W]]
                   : r_buf[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_base_hs  = base_valid  & base_ready;
  assign w_patch_hs = patch_valid & patch_ready;
  assign w_out_hs   = r_out_valid & out_ready;
  assign w_idx_bad  = (start_idx > end_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SIU_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    base_ready   = 1'b0;
    patch_ready  = 1'b0;
    case (r_state)
      SIU_IDLE: begin
        base_ready = 1'b1;
        if (base_valid) w_state_next = SIU_COLLECT;
      end
      SIU_COLLECT: begin
        patch_ready = 1'b1;
        if (patch_valid && patch_last) w_state_next = SIU_OUTPUT;
      end
      SIU_OUTPUT: begin
        if (out_ready) w_state_next = SIU_IDLE;
      end
      default: w_state_next = SIU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf        <= '0;
      r_data_out   <= '0;
      r_out_valid  <= 1'b0;
      r_idx_err    <= 1'b0;
      r_beat_count <= '0;
    end else begin
      if (w_base_hs) begin
        r_buf        <= base_in;
        r_idx_err    <= 1'b0;
        r_beat_count <= '0;
      end
      if (w_patch_hs) begin
        r_buf        <= w_next_buf;
        r_beat_count <= sat_inc(r_beat_count);
        if (w_idx_bad) r_idx_err <= 1'b1;
        if (patch_last) begin
          r_data_out  <= w_next_buf;
          r_out_valid <= 1'b1;
        end
      end
      if (w_out_hs) r_out_valid <= 1'b0;
    end
  end

  assign data_out   = r_data_out;
  assign out_valid  = r_out_valid;
  assign idx_err    = r_idx_err;
  assign beat_count = r_beat_count;

endmodule
